// File: rtl/decoder_scan.sv
// One-hot output decoder with four behaviours: direct select, continuous scan,
// single sweep and idle. All outputs come straight from registers.
module decoder_scan #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     w,
    input  logic             load,
    output logic [0:2**N-1]  y,
    output logic [N-1:0]     idx,
    output logic             busy,
    output logic             done
);

    localparam int NOUT = 2**N;
    localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_LAST   = '1;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN,
        SWEEP
    } state_t;

    state_t            state_reg, state_next;
    logic [N-1:0]      idx_reg, idx_next;
    logic [CW-1:0]     dwell_reg, dwell_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [0:NOUT-1]   y_reg, y_next;
    logic              dwell_wrap;
    logic              active_next;

    assign dwell_wrap = (dwell_reg == DWELL_LAST);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        dwell_next = dwell_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        // With en low everything holds; only y and done drop to zero.
        if (en) begin
            case (state_reg)
                IDLE: begin
                    if (mode == MODE_DIRECT && load) begin
                        idx_next   = w;
                        state_next = DIRECT;
                    end else if (mode == MODE_SCAN) begin
                        idx_next   = '0;
                        dwell_next = '0;
                        state_next = SCAN;
                    end else if (mode == MODE_SWEEP && load) begin
                        idx_next   = '0;
                        dwell_next = '0;
                        busy_next  = 1'b1;
                        state_next = SWEEP;
                    end
                end

                DIRECT: begin
                    if (mode != MODE_DIRECT) begin
                        state_next = IDLE;
                    end else if (load) begin
                        idx_next = w;
                    end
                end

                SCAN: begin
                    if (mode != MODE_SCAN) begin
                        state_next = IDLE;
                    end else if (dwell_wrap) begin
                        dwell_next = '0;
                        idx_next   = idx_reg + N'(1);
                    end else begin
                        dwell_next = dwell_reg + CW'(1);
                    end
                end

                SWEEP: begin
                    // load and mode are deliberately ignored until the sweep ends.
                    if (dwell_wrap && idx_reg == IDX_LAST) begin
                        dwell_next = '0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else if (dwell_wrap) begin
                        dwell_next = '0;
                        idx_next   = idx_reg + N'(1);
                    end else begin
                        dwell_next = dwell_reg + CW'(1);
                    end
                end

                default: state_next = IDLE;
            endcase
        end
    end

    assign active_next = en && (state_next != IDLE);

    generate
        for (genvar gi = 0; gi < NOUT; gi++) begin : g_onehot
            assign y_next[gi] = active_next && (idx_next == N'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            dwell_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            y_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            dwell_reg <= dwell_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            y_reg     <= y_next;
        end
    end

    assign y    = y_reg;
    assign idx  = idx_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan with N=3, DWELL=2.
module tb_decoder_scan;

    localparam int N     = 3;
    localparam int DWELL = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [1:0]     mode;
    logic [N-1:0]   w;
    logic           load;
    logic [0:7]     y;
    logic [N-1:0]   idx;
    logic           busy;
    logic           done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [0:7] y;
        logic [2:0] idx;
        logic       chk_idx;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    decoder_scan #(.N(N), .DWELL(DWELL)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .w    (w),
        .load (load),
        .y    (y),
        .idx  (idx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [0:7] oh(input int k);
        logic [0:7] r;
        r = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push the expectation for the inputs just driven, clock once, then pop and compare.
    task automatic step(input string tag, input logic [0:7] ey, input logic [2:0] eidx,
                        input logic cidx, input logic eb, input logic ed);
        exp_t e;
        e.tag = tag; e.y = ey; e.idx = eidx; e.chk_idx = cidx; e.busy = eb; e.done = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "_y"}, 32'(y), 32'(e.y));
        if (e.chk_idx) check({e.tag, "_idx"}, 32'(idx), 32'(e.idx));
        check({e.tag, "_busy"}, 32'(busy), 32'(e.busy));
        check({e.tag, "_done"}, 32'(done), 32'(e.done));
        check({e.tag, "_onehot"}, 32'($countones(y) <= 1), 32'(1));
        check({e.tag, "_bd_excl"}, 32'(busy && done), 32'(0));
        if (y != '0) check({e.tag, "_y_vs_idx"}, 32'(y), 32'(oh(int'(idx))));
        $display("[TB] %s y=%b idx=%0d busy=%0b done=%0b", e.tag, y, idx, busy, done);
    endtask

    initial begin
        int k;
        rst = 1'b1; en = 1'b0; mode = 2'b00; w = '0; load = 1'b0;
        #2;

        // Reset holds everything at zero even with en and scan requested.
        step("rst0", 8'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        en = 1'b1; mode = 2'b01;
        step("rst1", 8'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0; mode = 2'b00;

        // Direct mode.
        w = 3'd5; load = 1'b1;
        step("dir_w5", 8'b00000100, 3'd5, 1'b1, 1'b0, 1'b0);
        load = 1'b0; w = 3'd1;
        step("dir_hold5", 8'b00000100, 3'd5, 1'b1, 1'b0, 1'b0);
        w = 3'd2; load = 1'b1;
        step("dir_w2", 8'b00100000, 3'd2, 1'b1, 1'b0, 1'b0);
        load = 1'b0; w = 3'd7;
        step("dir_hold2", 8'b00100000, 3'd2, 1'b1, 1'b0, 1'b0);
        mode = 2'b01;
        step("dir_exit", 8'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Continuous scan with a 3-cycle enable gap at idx 3.
        k = 0;
        for (int c = 0; c < 31; c++) begin
            en = !(c >= 23 && c < 26);
            if (en) begin
                step($sformatf("scan%0d", c), oh((k / DWELL) % 8), 3'((k / DWELL) % 8),
                     1'b1, 1'b0, 1'b0);
                k++;
            end else begin
                step($sformatf("scan_off%0d", c), 8'b0, 3'(((k - 1) / DWELL) % 8),
                     1'b1, 1'b0, 1'b0);
            end
        end
        mode = 2'b11;
        step("reserved_idle", 8'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Single sweep with disturbing inputs mid-way.
        for (int j = 0; j < 16; j++) begin
            mode = 2'b10; load = (j == 0);
            if (j == 6) begin mode = 2'b00; load = 1'b1; w = 3'd6; end
            if (j == 9) mode = 2'b11;
            if (j == 11) begin mode = 2'b10; load = 1'b1; end
            step($sformatf("sweep%0d", j), oh(j / DWELL), 3'(j / DWELL), 1'b1, 1'b1, 1'b0);
        end
        mode = 2'b10; load = 1'b0;
        step("sweep_done", 8'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step("sweep_after", 8'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Sweep aborted by reset at idx 4.
        for (int j = 0; j < 9; j++) begin
            load = (j == 0);
            step($sformatf("abort%0d", j), oh(j / DWELL), 3'(j / DWELL), 1'b1, 1'b1, 1'b0);
        end
        rst = 1'b1;
        step("abort_rst", 8'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0; mode = 2'b00;
        for (int j = 0; j < 3; j++)
            step($sformatf("abort_post%0d", j), 8'b0, 3'd0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter N, default 3: select width; output count is 2**N.
REQ-002 Parameter DWELL, default 4: clock cycles each output is held during scan/sweep; legal range 1..256.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  global enable; low forces y to all-zero and freezes state/counters.
REQ-006 mode  input  2  00 direct, 01 continuous scan, 10 single sweep, 11 reserved (treated as idle).
REQ-007 w  input  N  select index for direct mode.
REQ-008 load  input  1  single-cycle strobe; captures w (direct) or starts a sweep.
REQ-009 y  output  [0:2**N-1]  registered one-hot output; y[k] high selects index k (y[0] is leftmost bit).
REQ-010 idx  output  N  current registered index.
REQ-011 busy  output  1  high while a single sweep is in progress.
REQ-012 done  output  1  one-cycle pulse at sweep completion.

Function
REQ-013 States: IDLE, DIRECT, SCAN, SWEEP; encoding is free.
REQ-014 y shall be all-zero or exactly one-hot; y = onehot(idx) in DIRECT/SCAN/SWEEP with en high, else zero.
REQ-015 All outputs registered; latency from qualifying input edge to y change is one cycle.
REQ-016 IDLE: mode=00 and load -> idx<=w, go DIRECT; mode=01 -> idx<=0, dwell counter<=0, go SCAN; mode=10 and load -> idx<=0, busy<=1, go SWEEP; otherwise stay, y=0.
REQ-017 DIRECT: load captures new w into idx next cycle; load low holds idx; mode!=00 -> IDLE, y=0 next cycle.
REQ-018 SCAN: each index held exactly DWELL cycles, then idx increments; idx 2**N-1 wraps to 0; runs until mode!=01, then IDLE.
REQ-019 SWEEP: same stepping as SCAN, visiting indices 0..2**N-1 once; after the last index's DWELL cycles: done=1 for one cycle, busy=0, y=0, state IDLE, all in the same cycle.
REQ-020 SWEEP ignores load and mode changes; a sweep always completes unless rst.
REQ-021 DWELL=1: index advances every cycle; no gap cycles between indices.
REQ-022 en low: y<=0 next cycle; state, idx, dwell counter, busy held; inputs load/mode ignored; on en high, y resumes onehot(idx) next cycle and the dwell count continues from held value.
REQ-023 done never asserts outside SWEEP completion; busy and done never high in the same cycle.
REQ-024 mode=11 in any non-SWEEP state -> IDLE.

Reset
REQ-025 rst high at a clock edge: state IDLE, y=0, idx=0, busy=0, done=0, dwell counter=0, next cycle, regardless of en or state.
REQ-026 rst overrides all inputs, including mid-sweep; no done pulse is produced for an aborted sweep.

Verification (N=3, DWELL=2)
REQ-027 Reset, then en=1, mode=00, load with w=5 -> next cycle idx=5, y=00000100; then w=2 with load -> y=00100000.
REQ-028 mode=01 held 20 cycles -> y walks 10000000,01000000,... 2 cycles each, wraps 00000001 to 10000000 after cycle 16.
REQ-029 mode=10, load pulse -> busy=1 for 16 cycles over indices 0..7, then done=1 for one cycle, busy=0, y=0; extra load mid-sweep has no effect.
REQ-030 Mid-scan en=0 for 3 cycles at idx=3 -> y=0, idx stays 3; en=1 -> y=00010000 with remaining dwell honoured.
REQ-031 rst asserted at idx=4 of a sweep -> next cycle all outputs zero, no done pulse.
REQ-032 Every cycle of every test: y is zero or one-hot and matches idx when active.
